// File: rtl/complex_vector_pingpong_bank.sv
// rtl/complex_vector_pingpong_bank.sv - two-bank ping-pong row store with streamed and random read ports
`timescale 1ns/1ps

module complex_vector_pingpong_bank #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int depth_rows    = 128
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          total,
    input  logic                                 load_we,
    input  logic                                 we,
    input  logic [31:0]                          wr_addr,
    input  logic [element_width*no_of_units-1:0] wr_data,
    input  logic                                 outsider_read,
    input  logic [31:0]                          rd_addr,
    input  logic                                 swap,
    output logic [element_width*no_of_units-1:0] rd_data,
    output logic                                 rd_valid,
    output logic                                 rd_last,
    output logic [element_width*no_of_units-1:0] prev_data,
    output logic                                 stream_done,
    output logic                                 bank_sel,
    output logic                                 addr_err
);

    localparam int row_width = element_width * no_of_units;
    localparam int addr_bits = (depth_rows > 1) ? $clog2(depth_rows) : 1;
    localparam int cnt_bits  = $clog2(depth_rows + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    stream_state_t        state;
    logic [cnt_bits-1:0]  rd_ptr;
    logic [31:0]          rows_div;
    logic [cnt_bits-1:0]  rows;
    logic [cnt_bits-1:0]  last_row;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [addr_bits-1:0] wr_row;
    logic [addr_bits-1:0] rand_row;
    logic [addr_bits-1:0] stream_row;

    // Bank storage: index 0/1 is the physical bank, bank_sel picks the current one.
    logic [row_width-1:0] mem [0:1][0:depth_rows-1];

    // Row count for the stream; a zero or oversized quotient falls back to the full bank
    // so the last-row compare can never underflow.
    always_comb begin
        rows_div = total / 32'(no_of_units);
        if (rows_div == 32'd0 || rows_div > 32'(depth_rows)) begin
            rows = cnt_bits'(depth_rows);
        end else begin
            rows = rows_div[cnt_bits-1:0];
        end
        last_row = rows - cnt_bits'(1);
    end

    assign wr_in_range = (wr_addr < 32'(depth_rows));
    assign rd_in_range = (rd_addr < 32'(depth_rows));
    assign wr_row      = wr_addr[addr_bits-1:0];
    assign rand_row    = rd_addr[addr_bits-1:0];
    assign stream_row  = rd_ptr[addr_bits-1:0];

    // Bank writes: write-back goes to the next bank, initial load to the current bank.
    // bank_sel is sampled before any same-edge swap, so a we with swap lands in the bank
    // that becomes current. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_in_range) begin
            if (we) begin
                mem[~bank_sel][wr_row] <= wr_data;
            end
            if (load_we) begin
                mem[bank_sel][wr_row] <= wr_data;
            end
        end
    end

    // Sticky flag for any write strobe with an out-of-range row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err <= 1'b0;
        end else if ((we || load_we) && !wr_in_range) begin
            addr_err <= 1'b1;
        end
    end

    // Random read of the current bank, one-cycle latency, independent of the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_data <= '0;
        end else begin
            prev_data <= rd_in_range ? mem[bank_sel][rand_row] : '0;
        end
    end

    // Stream FSM: issues rows 0..rows-1 of the current bank, swap restarts on the other bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            stream_done <= 1'b0;
            bank_sel    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (swap) begin
                bank_sel    <= ~bank_sel;
                rd_ptr      <= '0;
                state       <= IDLE;
                stream_done <= 1'b0;
            end else if (outsider_read && state != DONE) begin
                rd_data  <= mem[bank_sel][stream_row];
                rd_valid <= 1'b1;
                if (rd_ptr >= last_row) begin
                    rd_last     <= 1'b1;
                    state       <= DONE;
                    stream_done <= 1'b1;
                end else begin
                    rd_ptr <= rd_ptr + cnt_bits'(1);
                    state  <= STREAM;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_vector_pingpong_bank.sv
// tb/tb_complex_vector_pingpong_bank.sv - self-checking bench for complex_vector_pingpong_bank
`timescale 1ns/1ps

module tb_complex_vector_pingpong_bank;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int DR = 128;
    localparam int RW = EW * NU;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   total;
    logic          load_we;
    logic          we;
    logic [31:0]   wr_addr;
    logic [RW-1:0] wr_data;
    logic          outsider_read;
    logic [31:0]   rd_addr;
    logic          swap;
    logic [RW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic [RW-1:0] prev_data;
    logic          stream_done;
    logic          bank_sel;
    logic          addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] ref_mem [2][DR];
    bit            ref_sel;
    bit            ref_err;

    complex_vector_pingpong_bank #(
        .element_width(EW),
        .no_of_units  (NU),
        .depth_rows   (DR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .total        (total),
        .load_we      (load_we),
        .we           (we),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .outsider_read(outsider_read),
        .rd_addr      (rd_addr),
        .swap         (swap),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .prev_data    (prev_data),
        .stream_done  (stream_done),
        .bank_sel     (bank_sel),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    function automatic int model_rows(input logic [31:0] t);
        int r;
        r = int'(t / NU);
        if (t == 0 || r == 0 || r > DR) return DR;
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input bit lw, input bit w, input int addr, input logic [RW-1:0] d);
        load_we = lw;
        we      = w;
        wr_addr = 32'(addr);
        wr_data = d;
        step();
        load_we = 1'b0;
        we      = 1'b0;
        if (addr < DR) begin
            if (w)  ref_mem[!ref_sel][addr] = d;
            if (lw) ref_mem[ref_sel][addr]  = d;
        end else if (lw || w) begin
            ref_err = 1'b1;
        end
    endtask

    task automatic pulse_read();
        outsider_read = 1'b1;
        step();
        outsider_read = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        step();
        swap = 1'b0;
        ref_sel = !ref_sel;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_checks++;
        if (prev_data !== '0) begin n_fail++; $display("FAIL reset_prev_data: got %h want 0", prev_data); end
        n_checks++;
        if ({rd_valid, rd_last, stream_done, bank_sel, addr_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {rd_valid, rd_last, stream_done, bank_sel, addr_err});
        end
        #2 reset = 1'b1;
        ref_sel = 1'b0;
        ref_err = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [RW-1:0] exp;
        total = 32'd32;
        for (int i = 0; i < 4; i++) do_write(1'b1, 1'b0, i, RW'(32'h11 * (i + 1)));
        for (int i = 0; i < 4; i++) begin
            pulse_read();
            exp = RW'(32'h11 * (i + 1));
            n_checks++;
            if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, rd_valid); end
            n_checks++;
            if (rd_data !== exp) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, rd_data, exp); end
            n_checks++;
            if (rd_last !== (i == 3)) begin n_fail++; $display("FAIL stream_last[%0d]: got %b want %b", i, rd_last, (i == 3)); end
            n_checks++;
            if (stream_done !== (i == 3)) begin n_fail++; $display("FAIL stream_done[%0d]: got %b want %b", i, stream_done, (i == 3)); end
        end
        pulse_read();
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra_valid: got %b want 0", rd_valid); end
        n_checks++;
        if (stream_done !== 1'b1) begin n_fail++; $display("FAIL stream_done_hold: got %b want 1", stream_done); end
    endtask

    task automatic test_pingpong();
        logic [RW-1:0] exp;
        for (int i = 0; i < 4; i++) do_write(1'b0, 1'b1, i, RW'(32'hA0 + i));
        do_swap();
        n_checks++;
        if (bank_sel !== 1'b1) begin n_fail++; $display("FAIL pingpong_bank_sel: got %b want 1", bank_sel); end
        n_checks++;
        if (stream_done !== 1'b0) begin n_fail++; $display("FAIL pingpong_done: got %b want 0", stream_done); end
        for (int i = 0; i < 4; i++) begin
            pulse_read();
            exp = RW'(32'hA0 + i);
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_fail++;
                $display("FAIL pingpong_data[%0d]: got v=%b %h want v=1 %h", i, rd_valid, rd_data, exp);
            end
        end
    endtask

    task automatic test_swap_write();
        we      = 1'b1;
        wr_addr = 32'd2;
        wr_data = RW'(32'hBEEF);
        ref_mem[!ref_sel][2] = RW'(32'hBEEF);
        do_swap();
        we      = 1'b0;
        rd_addr = 32'd2;
        step();
        n_checks++;
        if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL swapwr_bank_sel: got %b want 0", bank_sel); end
        n_checks++;
        if (prev_data !== RW'(32'hBEEF)) begin n_fail++; $display("FAIL swapwr_prev: got %h want beef", prev_data); end
    endtask

    task automatic test_collision();
        outsider_read = 1'b1;
        do_swap();
        outsider_read = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL collide_valid: got %b want 0", rd_valid); end
        n_checks++;
        if (bank_sel !== ref_sel) begin n_fail++; $display("FAIL collide_bank_sel: got %b want %b", bank_sel, ref_sel); end
        pulse_read();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== ref_mem[ref_sel][0]) begin
            n_fail++;
            $display("FAIL collide_row0: got v=%b %h want v=1 %h", rd_valid, rd_data, ref_mem[ref_sel][0]);
        end
    endtask

    task automatic test_bad_addr();
        do_write(1'b1, 1'b1, DR, rand_row());
        n_checks++;
        if (addr_err !== ref_err) begin n_fail++; $display("FAIL badaddr_err: got %b want %b", addr_err, ref_err); end
        rd_addr = 32'd0;
        step();
        n_checks++;
        if (prev_data !== ref_mem[ref_sel][0]) begin n_fail++; $display("FAIL badaddr_cur: got %h want %h", prev_data, ref_mem[ref_sel][0]); end
        do_swap();
        step();
        n_checks++;
        if (prev_data !== ref_mem[ref_sel][0]) begin n_fail++; $display("FAIL badaddr_next: got %h want %h", prev_data, ref_mem[ref_sel][0]); end
        n_checks++;
        if (addr_err !== 1'b1) begin n_fail++; $display("FAIL badaddr_sticky: got %b want 1", addr_err); end
    endtask

    task automatic test_random_stream();
        logic [31:0]   totals [5];
        logic [RW-1:0] expect_q [$];
        logic [RW-1:0] cur_exp;
        int            rows;
        int            a;
        totals[0] = 32'(8 * $urandom_range(1, 16));
        totals[1] = 32'd0;
        totals[2] = 32'(8 * 300);
        totals[3] = 32'd8;
        totals[4] = 32'(8 * $urandom_range(1, 16));
        for (int it = 0; it < 5; it++) begin
            total = totals[it];
            rows  = model_rows(total);
            for (int r = 0; r < rows; r++) do_write(1'b1, 1'($urandom_range(0, 1)), r, rand_row());
            expect_q.delete();
            for (int r = 0; r < rows; r++) expect_q.push_back(ref_mem[ref_sel][r]);
            for (int i = 0; i < rows; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                a             = $urandom_range(0, rows - 1);
                rd_addr       = 32'(a);
                cur_exp       = ref_mem[ref_sel][a];
                we            = 1'($urandom_range(0, 1));
                wr_addr       = 32'(a);
                wr_data       = rand_row();
                outsider_read = 1'b1;
                step();
                outsider_read = 1'b0;
                if (we) ref_mem[!ref_sel][a] = wr_data;
                we = 1'b0;
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== expect_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_stream[%0d.%0d]: got v=%b %h want v=1 %h", it, i, rd_valid, rd_data, expect_q[i]);
                end
                n_checks++;
                if (rd_last !== (i == rows - 1)) begin
                    n_fail++;
                    $display("FAIL rand_last[%0d.%0d]: got %b want %b", it, i, rd_last, (i == rows - 1));
                end
                n_checks++;
                if (prev_data !== cur_exp) begin
                    n_fail++;
                    $display("FAIL rand_prev[%0d.%0d]: got %h want %h", it, i, prev_data, cur_exp);
                end
            end
            n_checks++;
            if (stream_done !== 1'b1) begin n_fail++; $display("FAIL rand_done[%0d]: got %b want 1", it, stream_done); end
            pulse_read();
            n_checks++;
            if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rand_no_wrap[%0d]: got %b want 0", it, rd_valid); end
            do_swap();
            n_checks++;
            if (bank_sel !== ref_sel || stream_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_swap[%0d]: got sel=%b done=%b want sel=%b done=0", it, bank_sel, stream_done, ref_sel);
            end
        end
    endtask

    task automatic test_async_reset();
        total = 32'd32;
        for (int i = 0; i < 4; i++) do_write(1'b1, 1'b0, i, rand_row());
        for (int i = 0; i < 4; i++) do_write(1'b0, 1'b1, i, rand_row());
        pulse_read();
        pulse_read();
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (rd_data !== '0 || prev_data !== '0) begin
            n_fail++;
            $display("FAIL areset_data: got rd=%h prev=%h want 0", rd_data, prev_data);
        end
        n_checks++;
        if ({rd_valid, rd_last, stream_done, bank_sel, addr_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL areset_flags: got %b want 00000", {rd_valid, rd_last, stream_done, bank_sel, addr_err});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        ref_sel = 1'b0;
        ref_err = 1'b0;
        step();
        pulse_read();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== ref_mem[0][0]) begin
            n_fail++;
            $display("FAIL areset_row0: got v=%b %h want v=1 %h", rd_valid, rd_data, ref_mem[0][0]);
        end
        n_checks++;
        if (rd_last !== 1'b0 || bank_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_state: got last=%b sel=%b want 0 0", rd_last, bank_sel);
        end
    endtask

    initial begin
        reset         = 1'b0;
        total         = '0;
        load_we       = 1'b0;
        we            = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        outsider_read = 1'b0;
        rd_addr       = '0;
        swap          = 1'b0;
        ref_sel       = 1'b0;
        ref_err       = 1'b0;
        test_reset();
        test_stream();
        test_pingpong();
        test_swap_write();
        test_collision();
        test_bad_addr();
        test_random_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
